// File: rtl/parking_pkg.sv
// -----------------------------------------------------------------------------
// parking_pkg
// Shared definitions for the parking-lot occupancy controller:
//   - state_e   : controller FSM encoding (ST_IDLE, ST_DOOR)
//   - STAT_W    : width of the admission / reject statistics counters
//   - STAT_MAX  : saturation value of those counters
//   - sat_inc() : saturating increment used by the statistics counters
// -----------------------------------------------------------------------------
package parking_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DOOR = 1'b1
  } state_e;

  localparam int STAT_W = 16;
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // Counters stick at STAT_MAX instead of wrapping back to zero.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == STAT_MAX) ? value : value + 1'b1;
  endfunction

endpackage : parking_pkg

// File: rtl/parking_slot_finder.sv
// -----------------------------------------------------------------------------
// parking_slot_finder
// Purely combinational status decode of the occupancy vector.
// Ports:
//   occupancy   in   NUM_SLOTS  bit i = slot i occupied
//   best_place  out  IDX_W      lowest-index free slot, 0 when none is free
//   best_valid  out  1          at least one slot is free
//   free_count  out  CNT_W      number of free slots
// -----------------------------------------------------------------------------
module parking_slot_finder #(
  parameter  int NUM_SLOTS = 8,
  localparam int IDX_W     = $clog2(NUM_SLOTS),
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [IDX_W-1:0]     best_place,
  output logic                 best_valid,
  output logic [CNT_W-1:0]     free_count
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that leaves one unassigned infers a latch.
  always_comb begin
    best_place = '0;
    best_valid = 1'b0;
    free_count = '0;
    // Scan from the top down so the last hit written is the lowest free index.
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        best_place = IDX_W'(i);
        best_valid = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      free_count = free_count + CNT_W'(~occupancy[i]);
    end
  end

endmodule : parking_slot_finder

// File: rtl/parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_lot_ctrl
// Occupancy controller for an N-slot parking lot. Entry/exit sensor rises admit
// or release a car, open the door for DOOR_OPEN_CYCLES clocks, and events that
// arrive while the door is open are held one-deep per kind until it closes.
//
// Build option: define PARKING_STATS_EN to build the saturating admission and
// reject counters; without it entry_count / reject_count are tied to zero.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   entry_sensor     level, car at entry gate (already synchronised)
//   exit_sensor      level, car at exit gate (already synchronised)
//   exit_slot        slot being vacated, sampled on exit_sensor rise
//   occupancy        bit i = slot i occupied
//   free_count       number of free slots
//   best_place       lowest free slot (0 when full)
//   best_valid       a free slot exists
//   full             all slots occupied
//   door_open        door-open window active
//   reject_pulse     1-cycle: entry refused, lot full
//   exit_err         1-cycle: exit on a slot that was already free
//   entry_count      admitted cars (saturating)
//   reject_count     refused entries (saturating)
// -----------------------------------------------------------------------------
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter  int NUM_SLOTS        = 8,
  parameter  int DOOR_OPEN_CYCLES = 100,
  localparam int IDX_W            = $clog2(NUM_SLOTS),
  localparam int CNT_W            = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              entry_sensor,
  input  logic              exit_sensor,
  input  logic [IDX_W-1:0]  exit_slot,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [CNT_W-1:0]  free_count,
  output logic [IDX_W-1:0]  best_place,
  output logic              best_valid,
  output logic              full,
  output logic              door_open,
  output logic              reject_pulse,
  output logic              exit_err,
  output logic [STAT_W-1:0] entry_count,
  output logic [STAT_W-1:0] reject_count
);

  // A one-cycle window still needs a 1-bit timer.
  localparam int TMR_W = (DOOR_OPEN_CYCLES > 1) ? $clog2(DOOR_OPEN_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DOOR_OPEN_CYCLES - 1);
  localparam logic [NUM_SLOTS-1:0] SLOT_ONE = {{(NUM_SLOTS-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic                 entry_sensor_q, exit_sensor_q;
  logic                 pend_entry_q, pend_entry_d;
  logic                 pend_exit_q, pend_exit_d;
  logic [IDX_W-1:0]     pend_slot_q, pend_slot_d;
  logic                 reject_q, reject_d;
  logic                 exit_err_q, exit_err_d;

  logic                 entry_rise, exit_rise;
  logic [IDX_W-1:0]     exit_sel;
  logic [NUM_SLOTS-1:0] exit_mask, entry_mask;
  logic                 exit_hit;

  assign entry_rise = entry_sensor & ~entry_sensor_q;
  assign exit_rise  = exit_sensor & ~exit_sensor_q;

  // A pending exit is older than a fresh rise, so it is served first.
  assign exit_sel   = pend_exit_q ? pend_slot_q : exit_slot;
  // Shifting past the top bit yields an empty mask, so an out-of-range slot
  // reads as free and is reported through exit_err.
  assign exit_mask  = SLOT_ONE << exit_sel;
  assign entry_mask = SLOT_ONE << best_place;
  assign exit_hit   = |(occ_q & exit_mask);

  parking_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_slot_finder (
    .occupancy  (occ_q),
    .best_place (best_place),
    .best_valid (best_valid),
    .free_count (free_count)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    occ_d        = occ_q;
    pend_entry_d = pend_entry_q;
    pend_exit_d  = pend_exit_q;
    pend_slot_d  = pend_slot_q;
    reject_d     = 1'b0;
    exit_err_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pend_exit_q || exit_rise) begin
          if (exit_hit) begin
            occ_d   = occ_q & ~exit_mask;
            timer_d = TMR_LOAD;
            state_d = ST_DOOR;
          end else begin
            exit_err_d = 1'b1;
          end
          // A rise arriving while a pending exit is being served replaces it.
          pend_exit_d = pend_exit_q & exit_rise;
          if (pend_exit_q && exit_rise) pend_slot_d = exit_slot;
          // The exit owns this cycle; any entry waits its turn.
          pend_entry_d = pend_entry_q | entry_rise;
        end else if (pend_entry_q || entry_rise) begin
          if (best_valid) begin
            occ_d   = occ_q | entry_mask;
            timer_d = TMR_LOAD;
            state_d = ST_DOOR;
          end else begin
            reject_d = 1'b1;
          end
          pend_entry_d = pend_entry_q & entry_rise;
        end
      end

      ST_DOOR: begin
        // One-deep queue per kind; a second rise of the same kind is dropped.
        if (exit_rise && !pend_exit_q) begin
          pend_exit_d = 1'b1;
          pend_slot_d = exit_slot;
        end
        if (entry_rise) pend_entry_d = 1'b1;
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      occ_q          <= '0;
      entry_sensor_q <= 1'b0;
      exit_sensor_q  <= 1'b0;
      pend_entry_q   <= 1'b0;
      pend_exit_q    <= 1'b0;
      pend_slot_q    <= '0;
      reject_q       <= 1'b0;
      exit_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      occ_q          <= occ_d;
      entry_sensor_q <= entry_sensor;
      exit_sensor_q  <= exit_sensor;
      pend_entry_q   <= pend_entry_d;
      pend_exit_q    <= pend_exit_d;
      pend_slot_q    <= pend_slot_d;
      reject_q       <= reject_d;
      exit_err_q     <= exit_err_d;
    end
  end

`ifdef PARKING_STATS_EN
  logic [STAT_W-1:0] entry_cnt_q, reject_cnt_q;
  logic              admit;

  // An admission is exactly a slot bit going from free to occupied.
  assign admit = |(occ_d & ~occ_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_cnt_q  <= '0;
      reject_cnt_q <= '0;
    end else begin
      if (admit)    entry_cnt_q  <= sat_inc(entry_cnt_q);
      if (reject_d) reject_cnt_q <= sat_inc(reject_cnt_q);
    end
  end

  assign entry_count  = entry_cnt_q;
  assign reject_count = reject_cnt_q;
`else
  assign entry_count  = '0;
  assign reject_count = '0;
`endif

  assign occupancy    = occ_q;
  assign full         = ~best_valid;
  assign door_open    = (state_q == ST_DOOR);
  assign reject_pulse = reject_q;
  assign exit_err     = exit_err_q;

endmodule : parking_lot_ctrl
